airlock_sequencer: RTL
======================

AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

Interface
REQ-001 SHALL have parameter EVAC_SECS, 7, seconds of evacuation countdown.
REQ-002 SHALL have parameter PRESS_SECS, 8, seconds of fill-and-pressurize countdown.
REQ-003 SHALL have parameter DWELL_SECS, 5, seconds a port stays open.
REQ-004 SHALL have port Clock  input  1  system clock, 50 MHz; one clock only.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tick  input  1  one-cycle 1 Hz pulse, synchronous to Clock.
REQ-007 SHALL have port arrive_req  input  1  level request: craft outside wants in.
REQ-008 SHALL have port depart_req  input  1  level request: craft inside wants out.
REQ-009 SHALL have port abort  input  1  one-cycle abort pulse.
REQ-010 SHALL have port outer_open, inner_open  output  1 each  port open commands.
REQ-011 SHALL have port evac_on, press_on  output  1 each  pump commands.
REQ-012 SHALL have port grant_arrive, grant_depart  output  1 each  current owner.
REQ-013 SHALL have port done  output  1  one-cycle pulse when a sequence completes.
REQ-014 SHALL have port remaining  output  4  seconds left in the current timed step.
REQ-015 SHALL have port state  output  4  encoded FSM state, for display and debug.

Function
REQ-016 SHALL implement the states IDLE, EVAC, OPEN_OUT, PRESS, OPEN_IN and ABORT_PRESS.
REQ-017 In IDLE, the chamber is pressurized, both ports are closed, both pumps are off and remaining=0.
REQ-018 In IDLE with exactly one request high, the FSM SHALL grant that requester on the next edge.
REQ-019 In IDLE with both requests high, the FSM SHALL grant round-robin: the requester not granted last wins; after reset, arrive wins.
REQ-020 The arrive sequence SHALL be EVAC, OPEN_OUT, PRESS, OPEN_IN, IDLE.
REQ-021 The depart sequence SHALL be OPEN_IN, EVAC, OPEN_OUT, PRESS, IDLE.
REQ-022 On entry to any timed state, remaining SHALL load that state's seconds value.
REQ-023 remaining SHALL decrement on each tick and be saturating, never wrapping below 0.
REQ-024 The FSM SHALL leave a timed state on the tick where remaining==1; the next state takes effect on the following edge.
REQ-025 EVAC asserts evac_on only; PRESS and ABORT_PRESS assert press_on only; OPEN_OUT asserts outer_open only; OPEN_IN asserts inner_open only.
REQ-026 outer_open and inner_open SHALL never be high together, and no port SHALL be open while a pump is on.
REQ-027 The grant SHALL hold for the whole sequence; requests are ignored while not in IDLE.
REQ-028 done SHALL pulse on the edge returning to IDLE from PRESS or OPEN_IN; the grant SHALL clear on that same edge.
REQ-029 A tick arriving in the same cycle as a request in IDLE SHALL NOT decrement the newly loaded count.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 Reset low SHALL force IDLE, all outputs to 0, and last-grant to depart (so arrive wins first), asynchronously.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no done pulse; any open port closes immediately.

Configuration
REQ-033 With AIRLOCK_ABORT_EN defined, abort in EVAC SHALL move the FSM to ABORT_PRESS, which loads PRESS_SECS; on expiry it returns to IDLE with done=0.
REQ-034 With AIRLOCK_ABORT_EN defined, abort in any other state SHALL be ignored.
REQ-035 Without AIRLOCK_ABORT_EN, the abort port SHALL be present but ignored, and ABORT_PRESS SHALL be unreachable.

Structure
REQ-036 The state enum, the state encodings and the default second counts SHALL live in shared package airlock_pkg.
REQ-037 The countdown SHALL be one sub-module, step_timer, with load, value, tick, remaining and expire signals.

Verification
REQ-038 arrive_req pulse, tick every 4 cycles: expect EVAC 7 ticks, OPEN_OUT 5, PRESS 8, OPEN_IN 5, then done=1 for one cycle and IDLE.
REQ-039 depart_req: expect inner_open for 5 ticks before evac_on rises; outer_open for 5 ticks; then PRESS and IDLE.
REQ-040 Both requests high at reset release: grant_arrive first; both held after done: grant_depart next.
REQ-041 Every cycle, assert !(outer_open&&inner_open) and !((outer_open||inner_open)&&(evac_on||press_on)).
REQ-042 With AIRLOCK_ABORT_EN, abort at remaining=3 in EVAC: ABORT_PRESS with remaining=8, then IDLE with no done; without the macro, the sequence is unchanged.
REQ-043 Reset low during OPEN_OUT: outer_open=0 immediately (no clock edge needed), state=IDLE, and no done pulse.

Source files
------------

// File: rtl/airlock_pkg.sv
// Shared state encodings, default step durations and state-to-command decode for the airlock sequencer.
package airlock_pkg;

    localparam int CNT_W          = 4;
    localparam int DEF_EVAC_SECS  = 7;
    localparam int DEF_PRESS_SECS = 8;
    localparam int DEF_DWELL_SECS = 5;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_EVAC        = 4'd1,
        ST_OPEN_OUT    = 4'd2,
        ST_PRESS       = 4'd3,
        ST_OPEN_IN     = 4'd4,
        ST_ABORT_PRESS = 4'd5
    } state_t;

    typedef struct packed {
        logic outer_open;
        logic inner_open;
        logic evac_on;
        logic press_on;
    } cmd_t;

    // Exactly one actuator per state keeps the port/pump interlock structural.
    function automatic cmd_t state_cmds(input state_t s);
        cmd_t c;
        c = '0;
        case (s)
            ST_EVAC:        c.evac_on    = 1'b1;
            ST_PRESS:       c.press_on   = 1'b1;
            ST_ABORT_PRESS: c.press_on   = 1'b1;
            ST_OPEN_OUT:    c.outer_open = 1'b1;
            ST_OPEN_IN:     c.inner_open = 1'b1;
            default:        c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable saturating seconds countdown; load wins over a same-cycle tick.
// expire is combinational: tick arriving while remaining==1.
module step_timer #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic [W-1:0] remaining,
    output logic         expire
);

    logic [W-1:0] r_rem;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rem <= '0;
        end else if (load) begin
            r_rem <= value;
        end else if (tick && (r_rem != '0)) begin
            r_rem <= r_rem - W'(1);
        end
    end

    assign remaining = r_rem;
    assign expire    = tick && (r_rem == W'(1));

endmodule

// File: rtl/airlock_sequencer.sv
// Airlock arrive/depart sequencer with round-robin grant; all outputs registered, one edge after decision.
// Optional abort-to-repressurize from EVAC when AIRLOCK_ABORT_EN is defined; otherwise abort is ignored.
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter int EVAC_SECS  = DEF_EVAC_SECS,
    parameter int PRESS_SECS = DEF_PRESS_SECS,
    parameter int DWELL_SECS = DEF_DWELL_SECS
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       tick,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       abort,
    output logic       outer_open,
    output logic       inner_open,
    output logic       evac_on,
    output logic       press_on,
    output logic       grant_arrive,
    output logic       grant_depart,
    output logic       done,
    output logic [3:0] remaining,
    output logic [3:0] state
);

    localparam logic [CNT_W-1:0] EVAC_CNT  = CNT_W'(EVAC_SECS);
    localparam logic [CNT_W-1:0] PRESS_CNT = CNT_W'(PRESS_SECS);
    localparam logic [CNT_W-1:0] DWELL_CNT = CNT_W'(DWELL_SECS);

    state_t           r_state;
    cmd_t             r_cmd;
    logic             r_grant_arrive;
    logic             r_grant_depart;
    logic             r_done;
    logic             r_last_dep;

    state_t           w_next_state;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_grant_a;
    logic             w_grant_d;
    logic             w_done;
    logic             w_last_dep;
    logic             w_expire;
    logic [CNT_W-1:0] w_remaining;

`ifndef AIRLOCK_ABORT_EN
    logic             w_unused_abort;
    assign w_unused_abort = abort;
`endif

    step_timer #(.W(CNT_W)) u_step_timer (
        .Clock     (Clock),
        .Reset     (Reset),
        .load      (w_load),
        .value     (w_load_val),
        .tick      (tick),
        .remaining (w_remaining),
        .expire    (w_expire)
    );

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_grant_a    = r_grant_arrive;
        w_grant_d    = r_grant_depart;
        w_done       = 1'b0;
        w_last_dep   = r_last_dep;
        case (r_state)
            ST_IDLE: begin
                // With both requests up, whoever was not served last goes first.
                if (arrive_req && (!depart_req || r_last_dep)) begin
                    w_next_state = ST_EVAC;
                    w_load       = 1'b1;
                    w_load_val   = EVAC_CNT;
                    w_grant_a    = 1'b1;
                    w_last_dep   = 1'b0;
                end else if (depart_req) begin
                    w_next_state = ST_OPEN_IN;
                    w_load       = 1'b1;
                    w_load_val   = DWELL_CNT;
                    w_grant_d    = 1'b1;
                    w_last_dep   = 1'b1;
                end
            end
            ST_EVAC: begin
`ifdef AIRLOCK_ABORT_EN
                if (abort) begin
                    w_next_state = ST_ABORT_PRESS;
                    w_load       = 1'b1;
                    w_load_val   = PRESS_CNT;
                end else
`endif
                if (w_expire) begin
                    w_next_state = ST_OPEN_OUT;
                    w_load       = 1'b1;
                    w_load_val   = DWELL_CNT;
                end
            end
            ST_OPEN_OUT: begin
                if (w_expire) begin
                    w_next_state = ST_PRESS;
                    w_load       = 1'b1;
                    w_load_val   = PRESS_CNT;
                end
            end
            ST_PRESS: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_grant_arrive) begin
                        w_next_state = ST_OPEN_IN;
                        w_load_val   = DWELL_CNT;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_grant_a    = 1'b0;
                        w_grant_d    = 1'b0;
                        w_done       = 1'b1;
                    end
                end
            end
            ST_OPEN_IN: begin
                if (w_expire) begin
                    w_load = 1'b1;
                    if (r_grant_arrive) begin
                        w_next_state = ST_IDLE;
                        w_grant_a    = 1'b0;
                        w_grant_d    = 1'b0;
                        w_done       = 1'b1;
                    end else begin
                        w_next_state = ST_EVAC;
                        w_load_val   = EVAC_CNT;
                    end
                end
            end
            ST_ABORT_PRESS: begin
                // Aborted sequences end without a done pulse.
                if (w_expire) begin
                    w_next_state = ST_IDLE;
                    w_load       = 1'b1;
                    w_grant_a    = 1'b0;
                    w_grant_d    = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_load       = 1'b1;
                w_grant_a    = 1'b0;
                w_grant_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state        <= ST_IDLE;
            r_cmd          <= '0;
            r_grant_arrive <= 1'b0;
            r_grant_depart <= 1'b0;
            r_done         <= 1'b0;
            r_last_dep     <= 1'b1;
        end else begin
            r_state        <= w_next_state;
            r_cmd          <= state_cmds(w_next_state);
            r_grant_arrive <= w_grant_a;
            r_grant_depart <= w_grant_d;
            r_done         <= w_done;
            r_last_dep     <= w_last_dep;
        end
    end

    assign outer_open   = r_cmd.outer_open;
    assign inner_open   = r_cmd.inner_open;
    assign evac_on      = r_cmd.evac_on;
    assign press_on     = r_cmd.press_on;
    assign grant_arrive = r_grant_arrive;
    assign grant_depart = r_grant_depart;
    assign done         = r_done;
    assign remaining    = w_remaining;
    assign state        = r_state;

endmodule
